fifo2frame: RTL
===============

Name: fifo2frame

Overview:
Reads pixels from the line FIFO filled by the frame-to-FIFO stage and rebuilds the frame streaming interface (valid/ready plus sof/eof/sol/eol) for downstream processing. Frame geometry is fixed by parameters, and position flags are regenerated from internal pixel and line counters. Uses a 2-entry output buffer to absorb the 1-cycle FIFO read latency, so it sustains one pixel per clock under continuous ready.

Parameters:
DATA_WIDTH, 24, pixel width in bits
H_ACTIVE, 640, pixels per line (≥2)
V_ACTIVE, 480, lines per frame (≥2)
CNT_W, 11, width of the x and y counters; must satisfy 2^CNT_W > max(H_ACTIVE, V_ACTIVE)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
sw_rst  in  1  synchronous soft reset; flushes the block
fifo_empty  in  1  FIFO empty
fifo_popdata  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_pop
fifo_pop  out  1  FIFO read strobe
frm_val  out  1  frame data valid
frm_data  out  DATA_WIDTH  frame data
frm_sof  out  1  start of frame (first pixel, line 0)
frm_eof  out  1  end of frame (last pixel, last line)
frm_sol  out  1  start of line
frm_eol  out  1  end of line
frm_rdy  in  1  downstream ready
underrun  out  1  sticky flag: frm_rdy high, frm_val low, mid-frame
frame_done  out  1  1-cycle pulse after the eof transfer

Behaviour:
- Values under rst: buffer count 0, pop_d1 0, x 0, y 0, frm_val 0, frm_data 0, underrun 0, frame_done 0, fifo_pop 0.
- A transfer (xfer) occurs when frm_val & frm_rdy. frm_val and frm_data must stay stable until xfer.
- Buffer: 2 entries; frm_val = (buf_cnt != 0); frm_data = head entry.
- Pop rule (combinational): fifo_pop = ~fifo_empty & ~sw_rst & ~rst & ((buf_cnt + pop_d1 - xfer) < 2).
  - pop_d1 is fifo_pop registered.
  - When pop_d1 is set, fifo_popdata is written to the tail of the buffer at that clock edge.
  - A simultaneous xfer and write keeps buf_cnt unchanged.
- Latency: with the FIFO going non-empty in cycle n and the block idle:
  - fifo_pop is high in cycle n;
  - data is captured at the end of n+1;
  - frm_val is high in cycle n+2.
- Throughput: sustains 1 pixel/clk while the FIFO is non-empty and frm_rdy=1. Never pops past buffer capacity, so the buffer never overflows. No pop is issued while fifo_empty=1.
- Flags are combinational from x, y and valid; each is qualified by frm_val:
  - sol = x==0
  - eol = x==H_ACTIVE-1
  - sof = sol & y==0
  - eof = eol & y==V_ACTIVE-1
- Counters advance only on xfer:
  - x increments, wrapping to 0 after H_ACTIVE-1;
  - on an x wrap, y increments, wrapping to 0 after V_ACTIVE-1.
- frame_done is registered: high for the cycle following an eof xfer.
- underrun:
  - set when frm_rdy=1, frm_val=0 and (x!=0 | y!=0);
  - never set between frames, i.e. at x=y=0;
  - cleared only by rst or sw_rst.
- sw_rst (synchronous, dominant):
  - clears buffer, pop_d1, x, y, underrun and frame_done at the next edge;
  - any read data arriving for a pop issued before sw_rst is discarded;
  - fifo_pop is held 0 while sw_rst=1.
  - The FIFO itself is flushed by its own reset.
- Asynchronous rst mid-frame forces reset values immediately. After reset, the next pixel delivered carries sof.

Decomposition:
- Shared package frm_pkg:
  - frame-flag struct {sof, eof, sol, eol};
  - default geometry constants H_ACTIVE_DEF and V_ACTIVE_DEF;
  - a clog2-based CNT_W helper.
- One sub-module: frm_skid_buf.
  - Parameterised 2-entry data buffer.
  - Ports: wr_en, wr_data, rd_en, rd_data, count.
  - Reused by later streaming stages.
- Counters and flag logic stay in the top level.

Test Plan:
- Reset and latency: release rst, FIFO pre-loaded with 4 words, frm_rdy=1 → fifo_pop in cycle 0; frm_val first high in cycle 2; data matches FIFO order; first pixel has sof=1, sol=1.
- Full frame with H_ACTIVE=4, V_ACTIVE=3, continuous ready → 12 back-to-back transfers.
  - eol on transfers 4, 8 and 12; sol on transfers 1, 5 and 9; eof only on transfer 12.
  - frame_done pulses one cycle later; transfer 13 carries sof.
- Backpressure: random frm_rdy (≈50%) → no data loss or duplication, buffer count ≤2, frm_data stable while frm_val=1 & frm_rdy=0.
- Underrun: FIFO empties after pixel 5 with frm_rdy=1 → underrun=1 and stays set after refill. Emptying at the frame boundary (x=y=0) leaves underrun=0.
- sw_rst mid-line, asserted 1 cycle at x=2 with a pop in flight → frm_val=0 the next cycle, in-flight word discarded, next delivered pixel has sof=1, underrun cleared.
- Simultaneous write and transfer with buf_cnt=1, pop_d1=1, xfer=1 → buf_cnt stays 1 and a new pop is issued in the same cycle.

Source files
------------

// File: rtl/frm_pkg.sv
// Shared types and geometry helpers for the frame streaming stages.
package frm_pkg;

  typedef struct packed {
    logic sof;
    logic eof;
    logic sol;
    logic eol;
  } frm_flags_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Smallest counter width whose range exceeds both dimensions.
  function automatic int cnt_w(input int h, input int v);
    int m;
    m = (h > v) ? h : v;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/frm_skid_buf.sv
// Two-entry in-order data buffer with write, read and clear.
import frm_pkg::*;

module frm_skid_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         rd;
  logic         wr;

  assign rd = rd_en & (cnt_q != 2'd0);
  assign wr = wr_en & ((cnt_q != 2'd2) | rd);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else begin
      case ({wr, rd})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = wr_data;
          else               e1_d = wr_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        // Read and write together: occupancy is unchanged.
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = wr_data;
          end else begin
            e0_d = e1_q;
            e1_d = wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_data = e0_q;
  assign count   = cnt_q;

endmodule

// File: rtl/fifo2frame.sv
// Line FIFO reader that rebuilds the frame stream with position flags.
import frm_pkg::*;

module fifo2frame #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int CNT_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_popdata,
  output logic                  fifo_pop,
  output logic                  frm_val,
  output logic [DATA_WIDTH-1:0] frm_data,
  output logic                  frm_sof,
  output logic                  frm_eof,
  output logic                  frm_sol,
  output logic                  frm_eol,
  input  logic                  frm_rdy,
  output logic                  underrun,
  output logic                  frame_done
);

  logic [1:0]       buf_cnt;
  logic             pop_d1_q;
  logic             xfer;
  logic [2:0]       occ;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             und_q, und_d;
  logic             done_q, done_d;
  logic             x_last;
  logic             y_last;
  frm_flags_t       flg;

  frm_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (sw_rst),
    .wr_en   (pop_d1_q & ~sw_rst),
    .wr_data (fifo_popdata),
    .rd_en   (xfer),
    .rd_data (frm_data),
    .count   (buf_cnt)
  );

  assign frm_val = (buf_cnt != 2'd0);
  assign xfer    = frm_val & frm_rdy;

  // Count the word already in flight so the buffer can never overflow.
  assign occ = 3'(buf_cnt) + 3'(pop_d1_q) - 3'(xfer);
  assign fifo_pop = ~fifo_empty & ~sw_rst & ~rst & (occ < 3'd2);

  assign x_last = (x_q == CNT_W'(H_ACTIVE - 1));
  assign y_last = (y_q == CNT_W'(V_ACTIVE - 1));

  always_comb begin
    flg = '0;
    if (frm_val) begin
      flg.sol = (x_q == '0);
      flg.eol = x_last;
      flg.sof = (x_q == '0) & (y_q == '0);
      flg.eof = x_last & y_last;
    end
  end

  assign frm_sof = flg.sof;
  assign frm_eof = flg.eof;
  assign frm_sol = flg.sol;
  assign frm_eol = flg.eol;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    und_d  = und_q;
    done_d = 1'b0;
    if (sw_rst) begin
      x_d   = '0;
      y_d   = '0;
      und_d = 1'b0;
    end else begin
      if (xfer) begin
        if (x_last) begin
          x_d = '0;
          y_d = y_last ? '0 : y_q + CNT_W'(1);
        end else begin
          x_d = x_q + CNT_W'(1);
        end
        done_d = flg.eof;
      end
      // Starving between frames is not an underrun.
      if (frm_rdy & ~frm_val & ((x_q != '0) | (y_q != '0)))
        und_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_d1_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      und_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pop_d1_q <= fifo_pop;
      x_q      <= x_d;
      y_q      <= y_d;
      und_q    <= und_d;
      done_q   <= done_d;
    end
  end

  assign underrun   = und_q;
  assign frame_done = done_q;

endmodule
